sram_arbiter: RTL

- Shares the single SRAM port among NUM_REQ requesters: fill block, line-buffer/raster writer and display/output reader.
- Each requester runs a req/done handshake. The arbiter picks one winner, latches its command and drives the SRAM enables for ACCESS_CYCLES cycles.
- It returns read data and a one-cycle done pulse to the winner.
- Default is round-robin fairness. The requester with the lowest index wins first after reset.

---
 rtl/gpu_sram_pkg.sv | 28 ++
 rtl/sram_arbiter_rr_picker.sv | 42 ++++
 rtl/sram_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/gpu_sram_pkg.sv
// Shared definitions for the GPU SRAM arbiter: the arbiter state encoding,
// requester indices, SRAM region bases and a small pointer-wrap helper.
package gpu_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2
    } arb_state_e;

    // Requester indices on the arbiter ports
    localparam int REQ_FILL   = 0;
    localparam int REQ_RASTER = 1;
    localparam int REQ_OUTPUT = 2;

    // SRAM region bases (word addresses); requesters build their own addresses
    localparam int unsigned LAYER0_BASE = 0;
    localparam int unsigned LAYER1_BASE = 65536;
    localparam int unsigned TEX1_BASE   = 131072;
    localparam int unsigned TEX2_BASE   = 135168;
    localparam int unsigned TEX3_BASE   = 139264;

    // Index after idx, wrapping modulo n
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sram_arbiter_rr_picker.sv
// rr_picker: combinational one-hot winner selection.
// Default: first set request at or after ptr_i, wrapping.
// With SRAM_ARB_FIXED_PRIO_EN defined: plain priority encoder, lowest index
// wins, and the ptr_i port does not exist.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
`ifndef SRAM_ARB_FIXED_PRIO_EN
    input  logic [PTR_W-1:0]   ptr_i,
`endif
    output logic [NUM_REQ-1:0] win_oh_o,
    output logic [PTR_W-1:0]   win_idx_o,
    output logic               any_o
);

    int   cand;
    logic found;

    // Scan candidates in priority order and keep the first one requesting
    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            cand = i;
`else
            cand = (int'(ptr_i) + i) % NUM_REQ;
`endif
            if (!found && req_i[cand[PTR_W-1:0]]) begin
                found                        = 1'b1;
                win_oh_o[cand[PTR_W-1:0]]    = 1'b1;
                win_idx_o                    = cand[PTR_W-1:0];
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM port between NUM_REQ req/done requesters.
// A transaction is IDLE (arbitrate and latch command) -> ACCESS for
// ACCESS_CYCLES cycles (enables/address held) -> COMPLETE (done pulse).
// Every output comes straight from a register.
// Optional build macro SRAM_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins, no rotating pointer) instead of round-robin.
module sram_arbiter
    import gpu_sram_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_SIZE_BITS = 24,
    parameter int DATA_BITS      = 1536,
    parameter int ACCESS_CYCLES  = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0]                req_we,
    input  logic [NUM_REQ*ADDR_SIZE_BITS-1:0] req_addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]                gnt,
    output logic [NUM_REQ-1:0]                done,
    output logic [DATA_BITS-1:0]              rdata,
    output logic                              busy,
    output logic                              sram_read_enable,
    output logic                              sram_write_enable,
    output logic [ADDR_SIZE_BITS-1:0]         sram_address,
    output logic [DATA_BITS-1:0]              sram_write_data,
    input  logic [DATA_BITS-1:0]              sram_read_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

    arb_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      we_q, we_d;
    logic [ADDR_SIZE_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0]      wdata_q, wdata_d;
    logic [NUM_REQ-1:0]        gnt_q, gnt_d;
    logic [NUM_REQ-1:0]        done_q, done_d;
    logic [DATA_BITS-1:0]      rdata_q, rdata_d;
    logic                      busy_q, busy_d;
    logic                      ren_q, ren_d;
    logic                      wen_q, wen_d;
    logic [ADDR_SIZE_BITS-1:0] saddr_q, saddr_d;
    logic [DATA_BITS-1:0]      swdata_q, swdata_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [PTR_W-1:0]          win_q, win_d;
`endif

    logic [NUM_REQ-1:0]        pick_oh;
    logic [PTR_W-1:0]          pick_idx;
    logic                      pick_any;
    logic                      sel_we;
    logic [ADDR_SIZE_BITS-1:0] sel_addr;
    logic [DATA_BITS-1:0]      sel_wdata;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i     (req),
`ifndef SRAM_ARB_FIXED_PRIO_EN
        .ptr_i     (ptr_q),
`endif
        .win_oh_o  (pick_oh),
        .win_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    // Route the winning requester's command fields out of the flattened buses
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_oh[k]) begin
                sel_we    = req_we[k];
                sel_addr  = req_addr[k*ADDR_SIZE_BITS +: ADDR_SIZE_BITS];
                sel_wdata = req_wdata[k*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        rdata_d  = rdata_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        saddr_d  = saddr_q;
        swdata_d = swdata_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        ptr_d    = ptr_q;
        win_d    = win_q;
`endif
        case (state_q)
            ST_IDLE: begin
                gnt_d    = '0;
                ren_d    = 1'b0;
                wen_d    = 1'b0;
                saddr_d  = '0;
                swdata_d = '0;
                if (pick_any) begin
                    state_d  = ST_ACCESS;
                    cnt_d    = '0;
                    we_d     = sel_we;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    gnt_d    = pick_oh;
                    wen_d    = sel_we;
                    ren_d    = ~sel_we;
                    saddr_d  = sel_addr;
                    swdata_d = sel_we ? sel_wdata : '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    win_d    = pick_idx;
`endif
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d  = ST_COMPLETE;
                    ren_d    = 1'b0;
                    wen_d    = 1'b0;
                    saddr_d  = '0;
                    swdata_d = '0;
                    done_d   = gnt_q;
                    if (!we_q) begin
                        rdata_d = sram_read_data;
                    end
                end
            end
            ST_COMPLETE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                ptr_d   = PTR_W'(wrap_inc(int'(win_q), NUM_REQ));
`endif
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                ren_d   = 1'b0;
                wen_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, latched command and registered outputs; reset aborts any access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            saddr_q  <= '0;
            swdata_q <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            ptr_q    <= '0;
            win_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            saddr_q  <= saddr_d;
            swdata_q <= swdata_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            ptr_q    <= ptr_d;
            win_q    <= win_d;
`endif
        end
    end

    assign gnt               = gnt_q;
    assign done              = done_q;
    assign rdata             = rdata_q;
    assign busy              = busy_q;
    assign sram_read_enable  = ren_q;
    assign sram_write_enable = wen_q;
    assign sram_address      = saddr_q;
    assign sram_write_data   = swdata_q;

endmodule
